// File: rtl/mipi_tx_frame_gen_if.sv
// Parallel video bus toward the MIPI CSI-2 TX core.
//   tx_vsync : frame sync, high for the VSYNC period
//   tx_hsync : line sync, high for the HSYNC period
//   tx_valid : active pixel qualifier
//   tx_data  : packed pixels, pixel x in [23:0], pixel x+1 in [47:24]
// master drives the bus (frame generator); slave consumes it (TX core / bench).
interface mipi_tx_frame_gen_if;
  logic        tx_vsync;
  logic        tx_hsync;
  logic        tx_valid;
  logic [63:0] tx_data;

  modport master (output tx_vsync, tx_hsync, tx_valid, tx_data);
  modport slave  (input  tx_vsync, tx_hsync, tx_valid, tx_data);
endinterface

// File: rtl/mipi_tx_frame_gen.sv
// Standalone frame source for the MIPI CSI-2 TX parallel interface.
// Produces VSYNC/HSYNC/VALID timing for back-to-back frames and fills the
// active region from one of four test patterns.
// Ports:
//   tx_pixel_clk : pixel clock
//   rstn         : async active-low reset, all outputs to 0
//   enable       : level, high = keep producing frames
//   pattern_sel  : 0 bars, 1 ramp, 2 solid, 3 frame/line/pixel counter
//   solid_rgb    : {R,G,B} for the solid pattern
//   tx           : video bus (master side)
//   frame_cnt    : completed frames, wraps
//   frame_done   : one-cycle pulse on the last VFP cycle
//   busy         : high whenever not idle
module mipi_tx_frame_gen #(
  parameter int HRES    = 1280,
  parameter int VRES    = 720,
  parameter int PPC     = 2,
  parameter int HS_CYC  = 4,
  parameter int HBP_CYC = 8,
  parameter int HFP_CYC = 16,
  parameter int VS_CYC  = 8,
  parameter int VBP_CYC = 32,
  parameter int VFP_CYC = 32
) (
  input  logic                tx_pixel_clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [1:0]          pattern_sel,
  input  logic [23:0]         solid_rgb,
  mipi_tx_frame_gen_if.master tx,
  output logic [15:0]         frame_cnt,
  output logic                frame_done,
  output logic                busy
);

  localparam logic [15:0] VS_LAST  = 16'(VS_CYC - 1);
  localparam logic [15:0] VBP_LAST = 16'(VBP_CYC - 1);
  localparam logic [15:0] HS_LAST  = 16'(HS_CYC - 1);
  localparam logic [15:0] HBP_LAST = 16'(HBP_CYC - 1);
  localparam logic [15:0] ACT_LAST = 16'(HRES / PPC - 1);
  localparam logic [15:0] HFP_LAST = 16'(HFP_CYC - 1);
  localparam logic [15:0] VFP_LAST = 16'(VFP_CYC - 1);
  localparam logic [15:0] VFP_PRE  = 16'(VFP_CYC - 2);
  localparam logic [15:0] Y_LAST   = 16'(VRES - 1);
  localparam logic [15:0] PX_STEP  = 16'(PPC);
  localparam logic [15:0] BAR_W    = 16'(HRES / 8);

  typedef enum logic [2:0] {IDLE, VS, VBP, HS, HBP, ACT, HFP, VFP} state_e;

  state_e      state_q;
  logic [15:0] cnt_q, x_q, y_q, bpos_q, frame_cnt_q;
  logic [2:0]  bar_q;
  logic [1:0]  pat_q;
  logic [23:0] solid_q;
  logic        vs_q, hs_q, val_q, done_q, busy_q;
  logic [63:0] data_q;

  logic        st_last;
  logic        in_act;
  logic [15:0] x_nxt, bpos_nxt;
  logic [2:0]  bar_nxt;
  logic [63:0] pix_word;

  always_comb begin
    st_last = 1'b0;
    unique case (state_q)
      IDLE: st_last = 1'b0;
      VS:   st_last = (cnt_q == VS_LAST);
      VBP:  st_last = (cnt_q == VBP_LAST);
      HS:   st_last = (cnt_q == HS_LAST);
      HBP:  st_last = (cnt_q == HBP_LAST);
      ACT:  st_last = (cnt_q == ACT_LAST);
      HFP:  st_last = (cnt_q == HFP_LAST);
      VFP:  st_last = (cnt_q == VFP_LAST);
    endcase
  end

  // Position of the pixels loaded on this edge: the first beat of a line
  // when entering ACT, otherwise one beat further along. Bar index is
  // tracked incrementally so no divider is needed; a beat never straddles
  // a bar edge because the bar width is a multiple of PPC.
  assign in_act   = (state_q == ACT);
  assign x_nxt    = in_act ? x_q + PX_STEP : '0;
  assign bar_nxt  = !in_act ? 3'd0 :
                    (bpos_q == BAR_W - PX_STEP) ? bar_q + 3'd1 : bar_q;
  assign bpos_nxt = !in_act ? '0 :
                    (bpos_q == BAR_W - PX_STEP) ? '0 : bpos_q + PX_STEP;

  for (genvar l = 0; l < PPC; l++) begin : g_lane
    logic [15:0] lx;
    logic [23:0] pix;
    assign lx = x_nxt + 16'(l);
    // Bar colours: R on for bars 0,1,4,5; G on for 0..3; B on for even bars.
    always_comb begin
      unique case (pat_q)
        2'd0:    pix = {{8{~bar_nxt[1]}}, {8{~bar_nxt[2]}}, {8{~bar_nxt[0]}}};
        2'd1:    pix = {3{lx[7:0]}};
        2'd2:    pix = solid_q;
        default: pix = {frame_cnt_q[7:0], y_q[7:0], lx[7:0]};
      endcase
    end
    assign pix_word[l*24 +: 24] = pix;
  end
  assign pix_word[63:PPC*24] = '0;

  always_ff @(posedge tx_pixel_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bar_q       <= '0;
      bpos_q      <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      val_q       <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q  <= (st_last || state_q == IDLE) ? '0 : cnt_q + 16'd1;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (enable) begin
          state_q <= VS;
          vs_q    <= 1'b1;
          busy_q  <= 1'b1;
          pat_q   <= pattern_sel;
          solid_q <= solid_rgb;
        end
        VS: if (st_last) begin
          state_q <= VBP;
          vs_q    <= 1'b0;
        end
        VBP: if (st_last) begin
          state_q <= HS;
          hs_q    <= 1'b1;
          y_q     <= '0;
          x_q     <= '0;
        end
        HS: if (st_last) begin
          state_q <= HBP;
          hs_q    <= 1'b0;
        end
        HBP: if (st_last) begin
          state_q <= ACT;
          val_q   <= 1'b1;
          data_q  <= pix_word;
          x_q     <= x_nxt;
          bar_q   <= bar_nxt;
          bpos_q  <= bpos_nxt;
        end
        ACT: begin
          if (st_last) begin
            state_q <= HFP;
            val_q   <= 1'b0;
            data_q  <= '0;
          end else begin
            data_q  <= pix_word;
            x_q     <= x_nxt;
            bar_q   <= bar_nxt;
            bpos_q  <= bpos_nxt;
          end
        end
        HFP: if (st_last) begin
          if (y_q == Y_LAST) begin
            state_q <= VFP;
            // A single-cycle VFP is itself the last VFP cycle.
            if (VFP_CYC == 1) begin
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end
          end else begin
            state_q <= HS;
            hs_q    <= 1'b1;
            y_q     <= y_q + 16'd1;
            x_q     <= '0;
          end
        end
        VFP: begin
          // Registered pulse: raise it on the edge entering the last cycle.
          if (VFP_CYC > 1 && cnt_q == VFP_PRE) begin
            done_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
          if (st_last) begin
            if (enable) begin
              state_q <= VS;
              vs_q    <= 1'b1;
              pat_q   <= pattern_sel;
              solid_q <= solid_rgb;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign tx.tx_vsync = vs_q;
  assign tx.tx_hsync = hs_q;
  assign tx.tx_valid = val_q;
  assign tx.tx_data  = data_q;
  assign frame_cnt   = frame_cnt_q;
  assign frame_done  = done_q;
  assign busy        = busy_q;

endmodule
